// File: rtl/rr_mux_select_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_mux_select_ctrl_pkg: shared types and the index-to-select map  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package rr_mux_select_ctrl_pkg;

    localparam int N_CH = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Returns {s0, s1}; channel k drives mux input i(k+1).
    function automatic logic [1:0] idx_to_sel(input logic [1:0] k);
        return {k[1], k[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_select_ctrl_pick4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick4: rotate-priority encoder, first request at/after ptr     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module rr_pick4
    import rr_mux_select_ctrl_pkg::*;
(
    input  logic [N_CH-1:0] req_i,
    input  logic [1:0]      ptr_i,
    output logic            found_o,
    output logic [1:0]      k_o
);

    logic [1:0] idx;

    // Scan from the farthest offset down so the nearest hit overwrites.
    always_comb begin
        found_o = 1'b0;
        k_o     = 2'd0;
        idx     = 2'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = ptr_i + 2'(i);
            if (req_i[idx]) begin
                found_o = 1'b1;
                k_o     = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_mux_select_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_mux_select_ctrl: round-robin grant and 4:1 mux select driver   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module rr_mux_select_ctrl
    import rr_mux_select_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req_i,
    output logic [N_CH-1:0] grant_o,
    output logic            mux_s0_o,
    output logic            mux_s1_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            abort_o
);

    localparam bit            WD_EN   = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e          state_q;
    logic [N_CH-1:0] grant_q;
    logic [1:0]      sel_q;
    logic            valid_q;
    logic            abort_q;
    logic [1:0]      ptr_q;
    logic [1:0]      idx_q;
    logic [TO_W-1:0] wd_q;

    logic            pick_found;
    logic [1:0]      pick_k;
    logic            wd_expire;

    rr_pick4 u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .k_o     (pick_k)
    );

    // This BUSY cycle is the TIMEOUT-th one without out_ready.
    assign wd_expire = WD_EN && (wd_q == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            wd_q    <= '0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_q <= ST_BUSY;
                        grant_q <= N_CH'(1) << pick_k;
                        sel_q   <= idx_to_sel(pick_k);
                        valid_q <= 1'b1;
                        idx_q   <= pick_k;
                        wd_q    <= '0;
                    end
                end
                ST_BUSY: begin
                    if (out_ready_i) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        ptr_q   <= idx_q + 2'd1;
                    end else if (!req_i[idx_q] || wd_expire) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        abort_q <= 1'b1;
                        ptr_q   <= idx_q + 2'd1;
                    end else begin
                        wd_q    <= wd_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign mux_s0_o    = sel_q[1];
    assign mux_s1_o    = sel_q[0];
    assign out_valid_o = valid_q;
    assign abort_o     = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_select_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rr_mux_select_ctrl: vectors, corner sequences, random vs model |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_rr_mux_select_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req0 = 4'd0, req1 = 4'd0;
    logic       rdy0 = 1'b0, rdy1 = 1'b0;
    logic [3:0] g0, g1;
    logic       s00, s10, v0, a0;
    logic       s01, s11, v1, a1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_mux_select_ctrl #(.TIMEOUT(0), .TO_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .grant_o(g0),
        .mux_s0_o(s00), .mux_s1_o(s10), .out_valid_o(v0),
        .out_ready_i(rdy0), .abort_o(a0)
    );

    rr_mux_select_ctrl #(.TIMEOUT(5), .TO_W(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .req_i(req1), .grant_o(g1),
        .mux_s0_o(s01), .mux_s1_o(s11), .out_valid_o(v1),
        .out_ready_i(rdy1), .abort_o(a1)
    );

    // Reference: one transaction in flight per unit, described by channel/wait count.
    bit m_busy[2];
    int m_ch[2];
    int m_wait[2];
    int m_ptr[2];
    int m_sel[2];
    bit m_abort[2];

    function automatic logic [7:0] dut_out(input int u);
        if (u == 0) return {g0, s00, s10, v0, a0};
        return {g1, s01, s11, v1, a1};
    endfunction

    function automatic logic [7:0] model_out(input int u);
        logic [3:0] g;
        g = m_busy[u] ? (4'b0001 << m_ch[u]) : 4'b0000;
        return {g, 1'((m_sel[u] / 2) % 2), 1'(m_sel[u] % 2), m_busy[u], m_abort[u]};
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_busy[u] = 0; m_ch[u] = 0; m_wait[u] = 0;
            m_ptr[u] = 0; m_sel[u] = 0; m_abort[u] = 0;
        end
    endtask

    task automatic model_step(input int u, input logic [3:0] r, input logic rd, input int to);
        bit found;
        m_abort[u] = 0;
        if (!m_busy[u]) begin
            found = 0;
            for (int off = 0; off < 4; off++) begin
                if (!found && r[(m_ptr[u] + off) % 4]) begin
                    found = 1;
                    m_ch[u] = (m_ptr[u] + off) % 4;
                end
            end
            if (found) begin
                m_busy[u] = 1; m_sel[u] = m_ch[u]; m_wait[u] = 0;
            end
        end else if (rd) begin
            m_busy[u] = 0; m_ptr[u] = (m_ch[u] + 1) % 4;
        end else if (!r[m_ch[u]] || (to > 0 && m_wait[u] + 1 >= to)) begin
            m_busy[u] = 0; m_abort[u] = 1; m_ptr[u] = (m_ch[u] + 1) % 4;
        end else begin
            m_wait[u]++;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (g,s0,s1,v,abort) at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit inv_ok(input logic [3:0] g, input logic v, input logic a);
        return $onehot0(g) && (v == (g != 4'd0)) && !(a && v);
    endfunction

    task automatic tick();
        model_step(0, req0, rdy0, 0);
        model_step(1, req1, rdy1, 5);
        @(posedge clk);
        #1;
        check("model0", dut_out(0), model_out(0));
        check("model5", dut_out(1), model_out(1));
        check("invariants", {6'd0, inv_ok(g0, v0, a0), inv_ok(g1, v1, a1)}, 8'b11);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 4'd0; req1 = 4'd0; rdy0 = 1'b0; rdy1 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset0", dut_out(0), 8'h00);
        check("reset5", dut_out(1), 8'h00);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // {req, rdy, expected {grant, s0, s1, valid, abort}} applied cycle by cycle from reset.
        vecs[0]  = '{4'b1111, 1'b1, {4'b0001, 2'b00, 1'b1, 1'b0}};
        vecs[1]  = '{4'b1111, 1'b1, {4'b0000, 2'b00, 1'b0, 1'b0}};
        vecs[2]  = '{4'b1111, 1'b1, {4'b0010, 2'b01, 1'b1, 1'b0}};
        vecs[3]  = '{4'b1111, 1'b1, {4'b0000, 2'b01, 1'b0, 1'b0}};
        vecs[4]  = '{4'b1111, 1'b1, {4'b0100, 2'b10, 1'b1, 1'b0}};
        vecs[5]  = '{4'b1111, 1'b1, {4'b0000, 2'b10, 1'b0, 1'b0}};
        vecs[6]  = '{4'b1111, 1'b1, {4'b1000, 2'b11, 1'b1, 1'b0}};
        vecs[7]  = '{4'b1111, 1'b1, {4'b0000, 2'b11, 1'b0, 1'b0}};
        vecs[8]  = '{4'b1111, 1'b1, {4'b0001, 2'b00, 1'b1, 1'b0}};
        vecs[9]  = '{4'b0000, 1'b1, {4'b0000, 2'b00, 1'b0, 1'b0}};
        vecs[10] = '{4'b0100, 1'b1, {4'b0100, 2'b10, 1'b1, 1'b0}};
        vecs[11] = '{4'b0000, 1'b1, {4'b0000, 2'b10, 1'b0, 1'b0}};
        vecs[12] = '{4'b0010, 1'b0, {4'b0010, 2'b01, 1'b1, 1'b0}};
        vecs[13] = '{4'b0010, 1'b0, {4'b0010, 2'b01, 1'b1, 1'b0}};
        vecs[14] = '{4'b0000, 1'b0, {4'b0000, 2'b01, 1'b0, 1'b1}};
        vecs[15] = '{4'b0011, 1'b0, {4'b0001, 2'b00, 1'b1, 1'b0}};
        vecs[16] = '{4'b0011, 1'b1, {4'b0000, 2'b00, 1'b0, 1'b0}};
        vecs[17] = '{4'b0000, 1'b0, {4'b0000, 2'b00, 1'b0, 1'b0}};

        do_reset();

        // Idle with no requests: nothing may move.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle0", dut_out(0), 8'h00);
        end

        do_reset();
        for (int i = 0; i < 18; i++) begin
            req0 = vecs[i].req;
            rdy0 = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d", i), dut_out(0), vecs[i].exp);
        end

        // Watchdog fires after the fifth BUSY cycle without ready.
        do_reset();
        req1 = 4'b1000; rdy1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wd_hold", dut_out(1), {4'b1000, 2'b11, 1'b1, 1'b0});
        end
        tick();
        check("wd_abort", dut_out(1), {4'b0000, 2'b11, 1'b0, 1'b1});
        req1 = 4'b1111;
        tick();
        check("wd_ptr_wrap", dut_out(1), {4'b0001, 2'b00, 1'b1, 1'b0});
        rdy1 = 1'b1;
        tick();
        // Ready arriving in the fifth BUSY cycle wins over the watchdog.
        req1 = 4'b1000; rdy1 = 1'b0;
        tick();
        check("wd2_grant", dut_out(1), {4'b1000, 2'b11, 1'b1, 1'b0});
        repeat (4) tick();
        rdy1 = 1'b1;
        tick();
        check("wd_ready_wins", dut_out(1), {4'b0000, 2'b11, 1'b0, 1'b0});
        req1 = 4'b0000; rdy1 = 1'b0;

        // With the watchdog disabled a stalled grant is held indefinitely.
        req0 = 4'b0001; rdy0 = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("no_wd_hold", dut_out(0), {4'b0001, 2'b00, 1'b1, 1'b0});

        // Asynchronous reset in the middle of a BUSY cycle.
        do_reset();
        req0 = 4'b0100; rdy0 = 1'b0;
        tick();
        check("pre_async", dut_out(0), {4'b0100, 2'b10, 1'b1, 1'b0});
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_clear", dut_out(0), 8'h00);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_async", dut_out(0), {4'b0100, 2'b10, 1'b1, 1'b0});

        // Randomised traffic against the reference model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 4; b++) req0[b] = ($urandom_range(0, 3) != 0);
            rdy0 = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 7) == 0) req1 = 4'($urandom_range(0, 15));
            rdy1 = ($urandom_range(0, 9) < 2);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
